// File: rtl/smp_pkg.sv
// Shared definitions for the SMP control unit: opcodes, ALU select codes,
// sequencer state encodings and the per-state strobe decode.
package smp_pkg;

    localparam int ALUS_BITS  = 7;
    localparam int STATE_BITS = 6;

    // Instruction opcodes carried in ir[3:0] (ir[7:4] must be zero)
    localparam logic [3:0] OP_NOP  = 4'h0, OP_LDAC = 4'h1, OP_STAC = 4'h2, OP_MVAC = 4'h3,
                           OP_MOVR = 4'h4, OP_JUMP = 4'h5, OP_JMPZ = 4'h6, OP_JPNZ = 4'h7,
                           OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_INAC = 4'hA, OP_CLAC = 4'hB,
                           OP_AND  = 4'hC, OP_OR   = 4'hD, OP_XOR  = 4'hE, OP_NOT  = 4'hF;

    // ALU function selects; NONE whenever AC is not being loaded
    localparam logic [ALUS_BITS-1:0] ALUS_NONE = 7'd0, ALUS_PASS = 7'd1, ALUS_ADD = 7'd2,
                                     ALUS_SUB  = 7'd3, ALUS_INC  = 7'd4, ALUS_CLR = 7'd5,
                                     ALUS_AND  = 7'd6, ALUS_OR   = 7'd7, ALUS_XOR = 7'd8,
                                     ALUS_NOT  = 7'd9;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE  = 6'd0,  ST_FETCH1 = 6'd1,  ST_FETCH2 = 6'd2,  ST_FETCH3 = 6'd3,
        ST_NOP1  = 6'd4,
        ST_LDAC1 = 6'd5,  ST_LDAC2  = 6'd6,  ST_LDAC3  = 6'd7,  ST_LDAC4  = 6'd8,  ST_LDAC5 = 6'd9,
        ST_STAC1 = 6'd10, ST_STAC2  = 6'd11, ST_STAC3  = 6'd12, ST_STAC4  = 6'd13,
        ST_STAC5 = 6'd14, ST_STAC6  = 6'd15,
        ST_MVAC1 = 6'd16, ST_MOVR1  = 6'd17,
        ST_JUMP1 = 6'd18, ST_JUMP2  = 6'd19, ST_JUMP3  = 6'd20,
        ST_JMPY1 = 6'd21, ST_JMPY2  = 6'd22, ST_JMPY3  = 6'd23,
        ST_JMPN1 = 6'd24, ST_JMPN2  = 6'd25,
        ST_ADD1  = 6'd26, ST_SUB1   = 6'd27, ST_INAC1  = 6'd28, ST_CLAC1  = 6'd29,
        ST_AND1  = 6'd30, ST_OR1    = 6'd31, ST_XOR1   = 6'd32, ST_NOT1   = 6'd33
    } state_t;

    typedef struct packed {
        logic                 we;
        logic                 membus;
        logic                 busmem;
        logic                 arload;
        logic                 arinc;
        logic                 pcload;
        logic                 pcinc;
        logic                 pcbus;
        logic                 drload;
        logic                 drhbus;
        logic                 drlbus;
        logic                 trload;
        logic                 trbus;
        logic                 irload;
        logic                 rload;
        logic                 rbus;
        logic                 acload;
        logic                 acbus;
        logic                 zload;
        logic [ALUS_BITS-1:0] alus;
    } ctrl_t;

    // Strobes asserted while the sequencer sits in a given state; unlisted
    // encodings (IDLE, NOP1, unused) assert nothing.
    function automatic ctrl_t state_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH1:           begin c.pcbus = 1'b1; c.arload = 1'b1; end
            ST_FETCH2:           begin c.membus = 1'b1; c.drload = 1'b1; c.pcinc = 1'b1; end
            ST_FETCH3:           begin c.irload = 1'b1; c.pcbus = 1'b1; c.arload = 1'b1; end
            ST_LDAC1, ST_STAC1:  begin c.membus = 1'b1; c.drload = 1'b1; c.pcinc = 1'b1; c.arinc = 1'b1; end
            ST_LDAC2, ST_STAC2:  begin c.trload = 1'b1; c.membus = 1'b1; c.drload = 1'b1; c.pcinc = 1'b1; end
            ST_LDAC3, ST_STAC3:  begin c.drhbus = 1'b1; c.trbus = 1'b1; c.arload = 1'b1; end
            ST_LDAC4, ST_STAC4:  begin c.membus = 1'b1; c.drload = 1'b1; end
            ST_LDAC5:            begin c.drlbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_PASS; end
            ST_STAC5:            begin c.acbus = 1'b1; c.drload = 1'b1; end
            ST_STAC6:            begin c.drlbus = 1'b1; c.busmem = 1'b1; c.we = 1'b1; end
            ST_MVAC1:            begin c.acbus = 1'b1; c.rload = 1'b1; end
            ST_MOVR1:            begin c.rbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_PASS; end
            ST_JUMP1, ST_JMPY1:  begin c.membus = 1'b1; c.drload = 1'b1; c.arinc = 1'b1; end
            ST_JUMP2, ST_JMPY2:  begin c.trload = 1'b1; c.membus = 1'b1; c.drload = 1'b1; end
            ST_JUMP3, ST_JMPY3:  begin c.drhbus = 1'b1; c.trbus = 1'b1; c.pcload = 1'b1; end
            ST_JMPN1, ST_JMPN2:  begin c.pcinc = 1'b1; end
            ST_ADD1:             begin c.rbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_ADD; end
            ST_SUB1:             begin c.rbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_SUB; end
            ST_INAC1:            begin c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_INC; end
            ST_CLAC1:            begin c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_CLR; end
            ST_AND1:             begin c.rbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_AND; end
            ST_OR1:              begin c.rbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_OR; end
            ST_XOR1:             begin c.rbus = 1'b1; c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_XOR; end
            ST_NOT1:             begin c.acload = 1'b1; c.zload = 1'b1; c.alus = ALUS_NOT; end
            default:             ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/smp_decode.sv
// Instruction decoder: ir[7:0] -> one-hot opcode. Any byte with a nonzero
// upper nibble is treated as NOP so illegal instructions simply fall through.
module smp_decode
    import smp_pkg::*;
(
    input  logic [7:0]  ir_lo,
    output logic [15:0] op_hot
);

    logic legal;
    assign legal = (ir_lo[7:4] == 4'h0);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_op
            assign op_hot[gi] = legal ? (ir_lo[3:0] == 4'(gi)) : (OP_NOP == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the 8-bit SMP datapath. Every strobe is held
// in a register that always equals the decode of the current state, so the
// outputs are glitch-free and drop together with the async reset.
module control_unit
    import smp_pkg::*;
#(
    parameter int ALUS_W = ALUS_BITS,
    parameter int ST_W   = STATE_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       ir,
    input  logic              z,
    output logic              we,
    output logic              MEMbus,
    output logic              BUSmem,
    output logic              ARload,
    output logic              ARinc,
    output logic              PCload,
    output logic              PCinc,
    output logic              PCbus,
    output logic              DRload,
    output logic              DRHbus,
    output logic              DRLbus,
    output logic              TRload,
    output logic              TRbus,
    output logic              IRload,
    output logic              Rload,
    output logic              Rbus,
    output logic [ALUS_W-1:0] ALUS,
    output logic              ACload,
    output logic              ACbus,
    output logic              Zload,
    output logic [ST_W-1:0]   state
);

    state_t      state_reg;
    state_t      state_next;
    ctrl_t       ctrl_reg;
    logic [15:0] op_hot;
    logic        unused_ir_hi;

    // Only the low byte of IR carries an opcode
    assign unused_ir_hi = ^ir[15:8];

    smp_decode u_decode (
        .ir_lo  (ir[7:0]),
        .op_hot (op_hot)
    );

    // Next-state: fixed chains per instruction, branching only in FETCH3
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH1;
            ST_FETCH1: state_next = ST_FETCH2;
            ST_FETCH2: state_next = ST_FETCH3;
            ST_FETCH3: begin
                case (1'b1)
                    op_hot[OP_LDAC]: state_next = ST_LDAC1;
                    op_hot[OP_STAC]: state_next = ST_STAC1;
                    op_hot[OP_MVAC]: state_next = ST_MVAC1;
                    op_hot[OP_MOVR]: state_next = ST_MOVR1;
                    op_hot[OP_JUMP]: state_next = ST_JUMP1;
                    op_hot[OP_JMPZ]: state_next = z ? ST_JMPY1 : ST_JMPN1;
                    op_hot[OP_JPNZ]: state_next = z ? ST_JMPN1 : ST_JMPY1;
                    op_hot[OP_ADD]:  state_next = ST_ADD1;
                    op_hot[OP_SUB]:  state_next = ST_SUB1;
                    op_hot[OP_INAC]: state_next = ST_INAC1;
                    op_hot[OP_CLAC]: state_next = ST_CLAC1;
                    op_hot[OP_AND]:  state_next = ST_AND1;
                    op_hot[OP_OR]:   state_next = ST_OR1;
                    op_hot[OP_XOR]:  state_next = ST_XOR1;
                    op_hot[OP_NOT]:  state_next = ST_NOT1;
                    default:         state_next = ST_NOP1;
                endcase
            end
            ST_LDAC1:  state_next = ST_LDAC2;
            ST_LDAC2:  state_next = ST_LDAC3;
            ST_LDAC3:  state_next = ST_LDAC4;
            ST_LDAC4:  state_next = ST_LDAC5;
            ST_STAC1:  state_next = ST_STAC2;
            ST_STAC2:  state_next = ST_STAC3;
            ST_STAC3:  state_next = ST_STAC4;
            ST_STAC4:  state_next = ST_STAC5;
            ST_STAC5:  state_next = ST_STAC6;
            ST_JUMP1:  state_next = ST_JUMP2;
            ST_JUMP2:  state_next = ST_JUMP3;
            ST_JMPY1:  state_next = ST_JMPY2;
            ST_JMPY2:  state_next = ST_JMPY3;
            ST_JMPN1:  state_next = ST_JMPN2;
            ST_LDAC5, ST_STAC6, ST_MVAC1, ST_MOVR1, ST_NOP1,
            ST_JUMP3, ST_JMPY3, ST_JMPN2,
            ST_ADD1, ST_SUB1, ST_INAC1, ST_CLAC1,
            ST_AND1, ST_OR1, ST_XOR1, ST_NOT1:
                       state_next = ST_FETCH1;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State and strobe registers; strobes are pre-decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= state_ctrl(state_next);
        end
    end

    assign we     = ctrl_reg.we;
    assign MEMbus = ctrl_reg.membus;
    assign BUSmem = ctrl_reg.busmem;
    assign ARload = ctrl_reg.arload;
    assign ARinc  = ctrl_reg.arinc;
    assign PCload = ctrl_reg.pcload;
    assign PCinc  = ctrl_reg.pcinc;
    assign PCbus  = ctrl_reg.pcbus;
    assign DRload = ctrl_reg.drload;
    assign DRHbus = ctrl_reg.drhbus;
    assign DRLbus = ctrl_reg.drlbus;
    assign TRload = ctrl_reg.trload;
    assign TRbus  = ctrl_reg.trbus;
    assign IRload = ctrl_reg.irload;
    assign Rload  = ctrl_reg.rload;
    assign Rbus   = ctrl_reg.rbus;
    assign ALUS   = ALUS_W'(ctrl_reg.alus);
    assign ACload = ctrl_reg.acload;
    assign ACbus  = ctrl_reg.acbus;
    assign Zload  = ctrl_reg.zload;
    assign state  = ST_W'(state_reg);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a cycle-level datapath model obeys the strobes,
// while an instruction-level model of the ISA predicts architectural results.
module tb_control_unit;
    import smp_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir    = 16'h0000;
    logic        z     = 1'b0;
    logic we, MEMbus, BUSmem, ARload, ARinc, PCload, PCinc, PCbus, DRload, DRHbus, DRLbus;
    logic TRload, TRbus, IRload, Rload, Rbus, ACload, ACbus, Zload;
    logic [6:0]  ALUS;
    logic [5:0]  state;
    logic [25:0] outs;

    assign outs = {we, MEMbus, BUSmem, ARload, ARinc, PCload, PCinc, PCbus, DRload, DRHbus,
                   DRLbus, TRload, TRbus, IRload, Rload, Rbus, ACload, ACbus, Zload, ALUS};

    control_unit dut (
        .clock(clock), .reset(reset), .ir(ir), .z(z), .we(we), .MEMbus(MEMbus), .BUSmem(BUSmem),
        .ARload(ARload), .ARinc(ARinc), .PCload(PCload), .PCinc(PCinc), .PCbus(PCbus),
        .DRload(DRload), .DRHbus(DRHbus), .DRLbus(DRLbus), .TRload(TRload), .TRbus(TRbus),
        .IRload(IRload), .Rload(Rload), .Rbus(Rbus), .ALUS(ALUS), .ACload(ACload),
        .ACbus(ACbus), .Zload(Zload), .state(state)
    );

    always #5 clock = ~clock;

    // Cycle-level datapath (drives ir and z back into the DUT)
    logic [15:0] dp_ar, dp_pc;
    logic [7:0]  dp_dr, dp_tr, dp_r, dp_ac;
    logic [7:0]  mem  [0:511];
    // Instruction-level reference
    logic [15:0] m_pc;
    logic [7:0]  m_ac, m_r;
    logic        m_z;
    logic [7:0]  rmem [0:511];

    int passes = 0;
    int checks = 0;
    int we_cnt, we_at, pcload_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic poke(input int addr, input logic [7:0] v);
        mem[addr]  = v;
        rmem[addr] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) poke(i, 8'h00);
    endtask

    // Called at a falling edge: check per-cycle rules, apply the strobes of
    // the current state to the datapath, then advance to the next falling edge.
    // IR is loaded mid-cycle so the new opcode is visible at the FETCH3 edge.
    task automatic cycle(input int idx);
        logic [7:0]  bl, bh, alu, o_dr;
        logic [15:0] bus16;
        check("bus_excl", {31'd0, $countones({MEMbus, DRLbus, TRbus, Rbus, ACbus, PCbus}) <= 1}, 1);
        check("drh_tr", {31'd0, !DRHbus || TRbus}, 1);
        check("we_busmem", {31'd0, !we || BUSmem}, 1);
        if (!ACload) check("alus_idle", {25'd0, ALUS}, 0);
        bl = MEMbus ? mem[dp_ar[8:0]] : DRLbus ? dp_dr : TRbus ? dp_tr : Rbus ? dp_r :
             ACbus ? dp_ac : PCbus ? dp_pc[7:0] : 8'h00;
        bh = PCbus ? dp_pc[15:8] : DRHbus ? dp_dr : 8'h00;
        bus16 = {bh, bl};
        case (ALUS)
            7'd1:    alu = bl;
            7'd2:    alu = dp_ac + bl;
            7'd3:    alu = dp_ac - bl;
            7'd4:    alu = dp_ac + 8'd1;
            7'd5:    alu = 8'h00;
            7'd6:    alu = dp_ac & bl;
            7'd7:    alu = dp_ac | bl;
            7'd8:    alu = dp_ac ^ bl;
            7'd9:    alu = ~dp_ac;
            default: alu = 8'h00;
        endcase
        o_dr = dp_dr;
        if (we) begin we_cnt++; we_at = idx; end
        if (PCload) pcload_cnt++;
        if (we && BUSmem) mem[dp_ar[8:0]] = bl;
        if (ARload) dp_ar = bus16; else if (ARinc) dp_ar = dp_ar + 16'd1;
        if (PCload) dp_pc = bus16; else if (PCinc) dp_pc = dp_pc + 16'd1;
        if (DRload) dp_dr = bl;
        if (TRload) dp_tr = o_dr;
        if (IRload) ir = {8'h00, o_dr};
        if (Rload) dp_r = bl;
        if (ACload) dp_ac = alu;
        if (Zload) z = (alu == 8'h00);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dp_ar = '0; dp_pc = '0; dp_dr = '0; dp_tr = '0; dp_r = '0; dp_ac = '0; ir = '0; z = 1'b0;
        m_pc = '0; m_ac = '0; m_r = '0; m_z = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_outs", {6'd0, outs}, 0);
        check("rst_state", {26'd0, state}, {26'd0, ST_IDLE});
        reset = 1'b0;
        #1;
        check("rel_outs", {6'd0, outs}, 0);
        check("rel_state", {26'd0, state}, {26'd0, ST_IDLE});
        @(negedge clock);
        check("f1_state", {26'd0, state}, {26'd0, ST_FETCH1});
        check("f1_strobes", {30'd0, PCbus, ARload}, 2'b11);
    endtask

    // Predict one instruction at ISA level, run the DUT until the next FETCH1
    // (bounded) and compare architectural state.
    task automatic exec_instr(output int n);
        logic [7:0]  op;
        logic [3:0]  op4;
        logic [15:0] pc1, pc2, a16;
        int          exp_cyc;
        op  = rmem[m_pc[8:0]];
        op4 = (op[7:4] == 4'h0) ? op[3:0] : 4'h0;
        pc1 = m_pc + 16'd1;
        pc2 = pc1 + 16'd1;
        a16 = {rmem[pc2[8:0]], rmem[pc1[8:0]]};
        exp_cyc = 4;
        m_pc = pc1;
        case (op4)
            4'h1: begin m_ac = rmem[a16[8:0]]; m_z = (m_ac == 0); m_pc = pc1 + 16'd2; exp_cyc = 8; end
            4'h2: begin rmem[a16[8:0]] = m_ac; m_pc = pc1 + 16'd2; exp_cyc = 9; end
            4'h3: m_r = m_ac;
            4'h4: begin m_ac = m_r; m_z = (m_ac == 0); end
            4'h5: begin m_pc = a16; exp_cyc = 6; end
            4'h6: if (m_z) begin m_pc = a16; exp_cyc = 6; end else begin m_pc = pc1 + 16'd2; exp_cyc = 5; end
            4'h7: if (!m_z) begin m_pc = a16; exp_cyc = 6; end else begin m_pc = pc1 + 16'd2; exp_cyc = 5; end
            4'h8: begin m_ac = m_ac + m_r; m_z = (m_ac == 0); end
            4'h9: begin m_ac = m_ac - m_r; m_z = (m_ac == 0); end
            4'hA: begin m_ac = m_ac + 8'd1; m_z = (m_ac == 0); end
            4'hB: begin m_ac = 8'h00; m_z = 1'b1; end
            4'hC: begin m_ac = m_ac & m_r; m_z = (m_ac == 0); end
            4'hD: begin m_ac = m_ac | m_r; m_z = (m_ac == 0); end
            4'hE: begin m_ac = m_ac ^ m_r; m_z = (m_ac == 0); end
            4'hF: begin m_ac = ~m_ac; m_z = (m_ac == 0); end
            default: ;
        endcase
        we_cnt = 0; we_at = 0; pcload_cnt = 0; n = 0;
        do begin
            n++;
            cycle(n);
        end while (state !== ST_FETCH1 && n < 24);
        check($sformatf("cycles op%0h", op4), n, exp_cyc);
        check($sformatf("pc op%0h", op4), {16'd0, dp_pc}, {16'd0, m_pc});
        check($sformatf("ac op%0h", op4), {24'd0, dp_ac}, {24'd0, m_ac});
        check($sformatf("r op%0h", op4), {24'd0, dp_r}, {24'd0, m_r});
        check($sformatf("z op%0h", op4), {31'd0, z}, {31'd0, m_z});
        if (op4 == 4'h2) begin
            check("stac_we_cnt", we_cnt, 1);
            check("stac_we_at", we_at, 9);
            check("stac_mem", {24'd0, mem[a16[8:0]]}, {24'd0, rmem[a16[8:0]]});
        end else begin
            check($sformatf("no_we op%0h", op4), we_cnt, 0);
        end
    endtask

    initial begin
        int n;
        logic [7:0] v;

        // LDAC from 0x0120 holding 00, then an illegal byte 0x3F as NOP
        clear_mem();
        poke(0, 8'h01); poke(1, 8'h20); poke(2, 8'h01); poke(3, 8'h3F);
        do_reset();
        exec_instr(n);
        check("ldac_cycles", n, 8);
        check("ldac_ac", {24'd0, dp_ac}, 0);
        check("ldac_z", {31'd0, z}, 1);
        check("ldac_pc", {16'd0, dp_pc}, 3);
        exec_instr(n);
        check("nop3f_pc", {16'd0, dp_pc}, 4);

        // JMPZ 0x0040 not taken
        clear_mem();
        poke(0, 8'h06); poke(1, 8'h40); poke(2, 8'h00);
        do_reset();
        exec_instr(n);
        check("jmpn_pc", {16'd0, dp_pc}, 3);
        check("jmpn_pcload", pcload_cnt, 0);

        // CLAC then JMPZ 0x0040 taken
        clear_mem();
        poke(0, 8'h0B); poke(1, 8'h06); poke(2, 8'h40); poke(3, 8'h00);
        do_reset();
        exec_instr(n);
        exec_instr(n);
        check("jmpy_pc", {16'd0, dp_pc}, 16'h0040);

        // R=03, AC=05: ADD, SUB x3, MVAC, XOR
        clear_mem();
        poke(0, 8'h01); poke(1, 8'h80); poke(2, 8'h01); poke(3, 8'h03);
        poke(4, 8'h01); poke(5, 8'h81); poke(6, 8'h01);
        poke(7, 8'h08); poke(8, 8'h09); poke(9, 8'h09); poke(10, 8'h09);
        poke(11, 8'h03); poke(12, 8'h0E);
        poke(9'h180, 8'h03); poke(9'h181, 8'h05);
        do_reset();
        repeat (3) exec_instr(n);
        exec_instr(n);
        check("add_ac", {24'd0, dp_ac}, 8'h08);
        check("add_z", {31'd0, z}, 0);
        exec_instr(n);
        exec_instr(n);
        check("sub2_ac", {24'd0, dp_ac}, 8'h02);
        exec_instr(n);
        check("sub3_ac", {24'd0, dp_ac}, 8'hFF);
        exec_instr(n);
        exec_instr(n);
        check("xor_ac", {24'd0, dp_ac}, 8'h00);
        check("xor_z", {31'd0, z}, 1);

        // STAC 0x0100 with AC=A5
        clear_mem();
        poke(0, 8'h01); poke(1, 8'h80); poke(2, 8'h01);
        poke(3, 8'h02); poke(4, 8'h00); poke(5, 8'h01);
        poke(9'h180, 8'hA5);
        do_reset();
        exec_instr(n);
        exec_instr(n);
        check("stac_a5", {24'd0, mem[9'h100]}, 8'hA5);

        // Reset in the middle of STAC3
        clear_mem();
        poke(0, 8'h02); poke(1, 8'h00); poke(2, 8'h01);
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(i);
        check("pre_rst_trbus", {31'd0, TRbus}, 1);
        reset = 1'b1;
        #1;
        check("midrst_outs", {6'd0, outs}, 0);
        check("midrst_state", {26'd0, state}, {26'd0, ST_IDLE});

        // Random program image, biased toward legal opcodes
        for (int i = 0; i < 512; i++) begin
            v = 8'($urandom);
            if ($urandom_range(3) != 0) v = {4'h0, v[3:0]};
            poke(i, v);
        end
        do_reset();
        for (int k = 0; k < 200; k++) exec_instr(n);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach summary in time");
        $fatal(1, "timeout");
    end

endmodule
